// File: rtl/usb_tx_pkg.sv
// usb_tx_pkg: line encodings, constants and state enum for the USB serial transmitter.
// Build option USB_TX_LOW_SPEED_EN swaps the D+/D- polarity of J and K for low-speed links.
package usb_tx_pkg;
    localparam logic [7:0] SYNC_PATTERN = 8'h80;
    localparam int STUFF_LIMIT = 6;
`ifdef USB_TX_LOW_SPEED_EN
    localparam logic [1:0] LINE_J = 2'b01;
    localparam logic [1:0] LINE_K = 2'b10;
`else
    localparam logic [1:0] LINE_J = 2'b10;
    localparam logic [1:0] LINE_K = 2'b01;
`endif
    localparam logic [1:0] LINE_SE0 = 2'b00;
    typedef enum logic [1:0] {IDLE, SYNC, DATA, EOP} tx_state_t;
    function automatic logic [1:0] line_enc(input logic j);
        return j ? LINE_J : LINE_K;
    endfunction
endpackage

// File: rtl/usb_nrzi_stuffer.sv
// usb_nrzi_stuffer: ones counter, stuff-bit insertion and NRZI line level (1 = J, 0 = K).
module usb_nrzi_stuffer
    import usb_tx_pkg::*;
(
    input  logic hi_clock,
    input  logic reset,
    input  logic emit,
    input  logic bit_in,
    input  logic clr,
    output logic stuff,
    output logic nxt
);
    logic [2:0] ones;
    logic       lvl;
    // while stuff is high the emitted symbol is a forced zero and the shifter must stall
    assign stuff = ones == 3'(STUFF_LIMIT);
    assign nxt = (bit_in && !stuff) ? lvl : !lvl;
    always_ff @(posedge hi_clock) begin
        if (reset || clr) begin
            ones <= '0;
            lvl  <= 1'b1;
        end else if (emit) begin
            lvl  <= nxt;
            ones <= (bit_in && !stuff) ? ones + 3'd1 : '0;
        end
    end
endmodule

// File: rtl/usb_fs_tx.sv
// usb_fs_tx: USB serial transmitter (SYNC, LSB-first data, bit stuffing, NRZI, EOP).
// Define USB_TX_LOW_SPEED_EN for low-speed line polarity (set CLKS_PER_BIT=32).
module usb_fs_tx
    import usb_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic       hi_clock,
    input  logic       reset,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    input  logic       tx_last,
    output logic       tx_ready,
    output logic       tx_active,
    output logic       tx_underrun,
    output logic       tx_plus,
    output logic       tx_minus,
    output logic       tx_oe
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    tx_state_t   state;
    logic [CW-1:0] cnt;
    logic [7:0]  sh, hold;
    logic [2:0]  rem;
    logic [1:0]  eop_cnt;
    logic        full, last_hold, last_taken, last_cur;
    logic        bnd, accept, bits, more, load, emit, ebit, stuff, nxt, clr;
    assign tx_ready = !full && !last_taken && state != EOP;
    always_comb begin
        bnd    = cnt == CW'(CLKS_PER_BIT - 1);
        accept = tx_valid && tx_ready;
        bits   = state == SYNC || state == DATA;
        more   = rem != 3'd0;
        load   = bits && bnd && !stuff && !more && !(state == DATA && last_cur) && full;
        emit   = (state == IDLE && accept) || (bits && bnd && (stuff || more)) || load;
        ebit   = state == IDLE ? 1'b0 : more ? sh[0] : hold[0];
        clr    = state == EOP && bnd && eop_cnt == 2'd2;
    end
    usb_nrzi_stuffer u_stuffer (
        .hi_clock(hi_clock),
        .reset(reset),
        .emit(emit),
        .bit_in(ebit),
        .clr(clr),
        .stuff(stuff),
        .nxt(nxt)
    );
    always_ff @(posedge hi_clock) begin
        if (reset) begin
            state                <= IDLE;
            cnt                  <= '0;
            sh                   <= '0;
            rem                  <= '0;
            eop_cnt              <= '0;
            hold                 <= '0;
            full                 <= 1'b0;
            last_hold            <= 1'b0;
            last_taken           <= 1'b0;
            last_cur             <= 1'b0;
            tx_active            <= 1'b0;
            tx_underrun          <= 1'b0;
            tx_oe                <= 1'b0;
            {tx_plus, tx_minus}  <= LINE_J;
        end else begin
            cnt         <= (bnd || (state == IDLE && accept)) ? '0 : cnt + CW'(1);
            tx_underrun <= 1'b0;
            if (emit)
                {tx_plus, tx_minus} <= line_enc(nxt);
            if (load) begin
                sh       <= {1'b0, hold[7:1]};
                rem      <= 3'd7;
                last_cur <= last_hold;
                full     <= 1'b0;
                state    <= DATA;
            end else if (bits && bnd && !stuff && more) begin
                sh  <= sh >> 1;
                rem <= rem - 3'd1;
            end else if (bits && bnd && !stuff) begin
                // byte exhausted with nothing to follow: either a clean end or an underrun
                state               <= EOP;
                eop_cnt             <= '0;
                {tx_plus, tx_minus} <= LINE_SE0;
                tx_underrun         <= !(state == DATA && last_cur);
            end
            if (state == EOP && bnd) begin
                eop_cnt <= eop_cnt + 2'd1;
                if (eop_cnt == 2'd1)
                    {tx_plus, tx_minus} <= LINE_J;
                if (eop_cnt == 2'd2) begin
                    state      <= IDLE;
                    tx_oe      <= 1'b0;
                    tx_active  <= 1'b0;
                    last_taken <= 1'b0;
                end
            end
            if (state == IDLE && accept) begin
                state     <= SYNC;
                tx_oe     <= 1'b1;
                tx_active <= 1'b1;
                sh        <= SYNC_PATTERN >> 1;
                rem       <= 3'd7;
                last_cur  <= 1'b0;
            end
            // accepted after any same-cycle load so the new byte lands in holding
            if (accept) begin
                hold      <= tx_data;
                full      <= 1'b1;
                last_hold <= tx_last;
                if (tx_last)
                    last_taken <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_usb_fs_tx.sv
// tb_usb_fs_tx: directed and random packets compared with a symbol-level model of the USB line.
`timescale 1ns/1ps
module tb_usb_fs_tx;
    localparam int C = 4;
`ifdef USB_TX_LOW_SPEED_EN
    localparam logic [1:0] J = 2'b01;
    localparam logic [1:0] K = 2'b10;
`else
    localparam logic [1:0] J = 2'b10;
    localparam logic [1:0] K = 2'b01;
`endif
    localparam logic [1:0] SE0 = 2'b00;

    logic       hi_clock = 1'b0;
    logic       reset = 1'b1;
    logic       tx_valid = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_last = 1'b0;
    logic       tx_ready, tx_active, tx_underrun, tx_plus, tx_minus, tx_oe;
    int         vectors = 0;
    int         miscompares = 0;
    int         ur_cnt = 0;
    int         act_bad = 0;
    logic [1:0] cap[$];
    logic [1:0] exp_sym[$];

    always #5 hi_clock = ~hi_clock;

    usb_fs_tx #(.CLKS_PER_BIT(C)) dut (
        .hi_clock(hi_clock),
        .reset(reset),
        .tx_valid(tx_valid),
        .tx_data(tx_data),
        .tx_last(tx_last),
        .tx_ready(tx_ready),
        .tx_active(tx_active),
        .tx_underrun(tx_underrun),
        .tx_plus(tx_plus),
        .tx_minus(tx_minus),
        .tx_oe(tx_oe)
    );

    always @(negedge hi_clock) begin
        if (tx_oe) cap.push_back({tx_plus, tx_minus});
        if (tx_underrun) ur_cnt++;
        if (tx_active !== tx_oe) act_bad++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // line symbols from the protocol rules: SYNC + data bits, NRZI, stuff after six ones, EOP
    task automatic build(input logic [7:0] b[$]);
        int   ones = 0;
        logic lvl = 1'b1;
        logic bs[$];
        exp_sym.delete();
        for (int i = 0; i < 8; i++) bs.push_back(i == 7);
        foreach (b[n]) for (int i = 0; i < 8; i++) bs.push_back(b[n][i]);
        foreach (bs[i]) begin
            if (bs[i]) ones++;
            else begin lvl = !lvl; ones = 0; end
            exp_sym.push_back(lvl ? J : K);
            if (ones == 6) begin
                lvl = !lvl;
                ones = 0;
                exp_sym.push_back(lvl ? J : K);
            end
        end
        exp_sym.push_back(SE0);
        exp_sym.push_back(SE0);
        exp_sym.push_back(J);
    endtask

    task automatic offer(input logic [7:0] d, input logic l);
        int t = 0;
        tx_valid = 1'b1;
        tx_data = d;
        tx_last = l;
        while (!tx_ready && t < 400) begin @(negedge hi_clock); t++; end
        check("accept_wait", t < 400, 1);
        @(negedge hi_clock);
    endtask

    task automatic run_pkt(input logic [7:0] b[$], input logic under);
        int base, ur0, t;
        build(b);
        base = cap.size();
        ur0 = ur_cnt;
        foreach (b[n]) offer(b[n], !under && n == b.size() - 1);
        tx_valid = 1'b0;
        tx_last = 1'b0;
        t = 0;
        while (tx_oe && t < 2000) begin
            if (!under) check("ready_low", tx_ready, 0);
            @(negedge hi_clock);
            t++;
        end
        check("eop_timeout", tx_oe, 0);
        check("ready_idle", tx_ready, 1);
        check("oe_cycles", cap.size() - base, exp_sym.size() * C);
        foreach (exp_sym[i])
            for (int k = 0; k < C; k++)
                if (base + i * C + k < cap.size())
                    check($sformatf("sym%0d", i), cap[base + i * C + k], exp_sym[i]);
        check("underrun", ur_cnt - ur0, under);
    endtask

    initial begin
        logic [7:0] q[$];
        repeat (3) @(negedge hi_clock);
        check("rst_line", {tx_plus, tx_minus}, J);
        check("rst_oe", tx_oe, 0);
        check("rst_active", tx_active, 0);
        check("rst_underrun", tx_underrun, 0);
        check("rst_ready", tx_ready, 1);
        reset = 1'b0;
        @(negedge hi_clock);
        q = '{8'h00};
        run_pkt(q, 0);
        q = '{8'hFF};
        run_pkt(q, 0);
        q = '{8'hA5, 8'h3C, 8'h0F};
        run_pkt(q, 0);
        q = '{8'h11};
        run_pkt(q, 1);
        // reset in the middle of the data phase abandons the packet without an EOP
        offer(8'h5A, 1'b1);
        tx_valid = 1'b0;
        repeat (12 * C) @(negedge hi_clock);
        check("mid_oe", tx_oe, 1);
        reset = 1'b1;
        @(negedge hi_clock);
        check("mid_rst_line", {tx_plus, tx_minus}, J);
        check("mid_rst_oe", tx_oe, 0);
        check("mid_rst_active", tx_active, 0);
        check("mid_rst_ready", tx_ready, 1);
        reset = 1'b0;
        repeat (2 * C) @(negedge hi_clock);
        check("no_eop_oe", tx_oe, 0);
        check("no_eop_line", {tx_plus, tx_minus}, J);
        q = '{8'h00};
        run_pkt(q, 0);
        for (int p = 0; p < 8; p++) begin
            q.delete();
            repeat ($urandom_range(1, 4)) q.push_back($urandom_range(0, 3) == 0 ? 8'hFF : 8'($urandom));
            repeat ($urandom_range(0, 5)) @(negedge hi_clock);
            run_pkt(q, $urandom_range(0, 3) == 0);
        end
        check("active_tracks_oe", act_bad, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/usb_fs_tx.md
Name: usb_fs_tx

Overview:
- USB full-speed serial transmitter for the host-facing upstream port.
- Accepts packet bytes over a valid/ready stream and emits SYNC, LSB-first data, bit stuffing, NRZI encoding and EOP.
- Drives host_tx_plus / host_tx_minus / output-enable in usb_hub_top.
- Counterpart to the hub's upstream receive path.

Parameters:
- CLKS_PER_BIT, 4, hi_clock cycles per USB bit time (48 MHz / 12 Mbps); legal range >= 2.

Ports:
- hi_clock  input  1  transmit clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- tx_valid  input  1  tx_data holds a packet byte.
- tx_data  input  8  packet byte (PID first); sent LSB first.
- tx_last  input  1  qualifies tx_data as the final byte of the packet.
- tx_ready  output  1  byte accepted when tx_valid && tx_ready.
- tx_active  output  1  high from first SYNC bit through end of EOP.
- tx_underrun  output  1  one-cycle pulse when a packet is aborted for missing data.
- tx_plus  output  1  D+ drive value.
- tx_minus  output  1  D- drive value.
- tx_oe  output  1  line output enable.

Behaviour:
- Reset values:
  - tx_plus=1, tx_minus=0 (J), tx_oe=0, tx_active=0, tx_underrun=0, tx_ready=1.
  - State IDLE; bit counter and ones counter cleared.
  - Reset mid-packet abandons the packet immediately with no EOP.
- Bit timing:
  - Free-running strobe counter 0..CLKS_PER_BIT-1, restarted on leaving IDLE.
  - Line outputs change only at strobe boundaries and hold CLKS_PER_BIT cycles per bit.
- Holding register:
  - One-byte holding register; tx_ready = holding empty and tx_last not yet accepted for the current packet.
  - The shift register loads from holding after the final bit of the current byte, with any trailing stuff bit pending.
- States:
  - IDLE: on an accepted byte go to SYNC. tx_oe, tx_active rise the next cycle, driving the first SYNC bit (K).
  - SYNC: 8 bits of 0x80 LSB first; line K J K J K J K K. Ones counter = 1 at exit.
  - DATA: shift bits. Bit 0 toggles J<->K; bit 1 holds the line and increments the ones counter.
    - After six consecutive ones, insert a 0 (toggle) and clear the counter. This also applies after the last data bit, before EOP.
    - After the last bit of a byte flagged tx_last (plus any stuff bit), go to EOP.
    - If a byte is needed, holding is empty, and tx_last was not taken: pulse tx_underrun and go to EOP.
  - EOP: SE0 (0,0) for 2 bit times, then J for 1 bit time. Then tx_oe=0, tx_active=0, ones counter cleared, tx_ready=1, state IDLE.
- Back-to-back packets: a byte offered while in EOP is not accepted until IDLE, so at least one idle cycle separates packets.
- Simultaneous accept and shift-load in the same cycle: the load takes the old holding content; the new byte lands in holding.

Optional Feature:
- USB_TX_LOW_SPEED_EN defined:
  - J = (tx_plus 0, tx_minus 1) and K = (1, 0); idle and reset drive (0, 1).
  - Integrator sets CLKS_PER_BIT=32 for 1.5 Mbps.
- Not defined: full-speed polarity as above.

Decomposition:
- Package usb_tx_pkg:
  - Line-state encodings J/K/SE0, SYNC_PATTERN = 8'h80, STUFF_LIMIT = 6.
  - Transmit state enum (IDLE, SYNC, DATA, EOP).
- Sub-module usb_nrzi_stuffer: takes a bit plus strobe; owns the ones counter, stuff insertion (stalling the shifter) and NRZI line state.

Test Plan:
- Single byte 0x00 (tx_last=1), CLKS_PER_BIT=4:
  - Line K J K J K J K K, J K J K J K J K, SE0 SE0 J.
  - tx_oe high exactly 76 cycles; tx_underrun never asserts.
- Single byte 0xFF (tx_last=1):
  - After SYNC: K K K K K, stuff J, J J J, then SE0 SE0 J.
  - 20 bit times total (80 cycles).
- Bytes 0xA5, 0x3C, 0x0F (last) with tx_valid held high:
  - Each accepted in turn with no gaps; decoded bitstream matches with zero stuff bits.
  - tx_ready low after 0x0F is accepted until IDLE.
- Byte 0x11 without tx_last, then tx_valid low:
  - tx_underrun pulses once at the byte boundary; SE0 SE0 J follows; tx_oe drops.
- reset asserted mid-DATA:
  - Next cycle tx_plus=1, tx_minus=0, tx_oe=0, tx_active=0, no EOP.
  - A fresh packet afterwards starts with a clean SYNC.
- With USB_TX_LOW_SPEED_EN and CLKS_PER_BIT=32, byte 0x00:
  - Same symbol sequence as the 0x00 case with D+/D- swapped; each bit lasts 32 cycles.
